// File: rtl/pmem_writeback_buffer.sv
// Single-entry eviction write buffer between the cache arbiter and physical memory.
// Optional read forwarding from the buffered line is enabled by defining WB_FWD_EN.
module pmem_writeback_buffer #(
   parameter int LINE_W   = 256,
   parameter int OFFSET_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              up_read,
   input  logic              up_write,
   input  logic [31:0]       up_address,
   input  logic [LINE_W-1:0] up_wdata,
   output logic              up_resp,
   output logic [LINE_W-1:0] up_rdata,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [31:0]       pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic              pmem_resp,
   input  logic [LINE_W-1:0] pmem_rdata
);

   localparam int TAG_W = 32 - OFFSET_W;

   typedef enum logic [1:0] {
      IDLE,
      ACK,
      RD,
      WB
   } state_t;

   state_t              state_q, state_d;
   logic                valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [LINE_W-1:0]   data_q, data_d;
   logic [LINE_W-1:0]   hold_q, hold_d;
   logic                match;

   assign match = valid_q && (up_address[31:OFFSET_W] == tag_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      data_d       = data_q;
      hold_d       = hold_q;
      up_resp      = 1'b0;
      up_rdata     = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;

      unique case (state_q)
         IDLE: begin
            // Reads beat the background drain; a conflicting write waits for it.
            if (up_write && (!valid_q || match)) begin
               tag_d   = up_address[31:OFFSET_W];
               data_d  = up_wdata;
               valid_d = 1'b1;
               state_d = ACK;
            end else if (up_write) begin
               state_d = WB;
            end else if (up_read && match) begin
`ifdef WB_FWD_EN
               hold_d  = data_q;
               state_d = ACK;
`else
               state_d = WB;
`endif
            end else if (up_read) begin
               state_d = RD;
            end else if (valid_q) begin
               state_d = WB;
            end
         end

         ACK: begin
            up_resp  = 1'b1;
            up_rdata = hold_q;
            state_d  = IDLE;
         end

         RD: begin
            pmem_read    = 1'b1;
            pmem_address = up_address;
            up_resp      = pmem_resp;
            up_rdata     = pmem_rdata;
            if (pmem_resp) begin
               state_d = IDLE;
            end
         end

         WB: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_q, {OFFSET_W{1'b0}}};
            pmem_wdata   = data_q;
            if (pmem_resp) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
